l2_line_memory_adapter: RTL and testbench
=========================================

// Module: l2_line_memory_adapter
// PURPOSE
//  Downstream neighbour of the L1 cache: serves its line-granular L2 requests (LOAD fill, STORE writeback)
//  from a word-wide main-memory BRAM port with fixed read latency. Serialises a Line into
//  CACHE_WORDS_PER_LINE word accesses and reassembles reads into one Line response.
//  Stands in for the L2 level until a real L2 exists; its line-side port is identical to the L1's L2 port.
// PARAMETERS
//  MEM_ADDR_WIDTH    16                     word-address width of main-memory BRAM
//  MEM_READ_LATENCY  2                      cycles from mem_address_out to valid mem_read_data_in (>=1)
//  WORDS_PER_LINE    CACHE_WORDS_PER_LINE   words per Line (power of two; taken from cache_help)
// PORTS
//  clk_in                   in   1                 clock
//  rst_n_in                 in   1                 reset, asynchronous, active-low
//  request_ready_out        out  1                 adapter can accept a line request
//  request_valid_in         in   1                 line request valid
//  request_address_in       in   Word              word address; low CACHE_WORD_OFFSET_WIDTH bits ignored
//  request_operation_in     in   MemoryOperation   LOAD = line fill, STORE = line writeback
//  request_data_in          in   Line              writeback data (STORE only)
//  response_ready_in        in   1                 consumer accepts response
//  response_valid_out       out  1                 fill line valid (LOAD only)
//  response_data_out        out  Line              fill line
//  mem_address_out          out  MEM_ADDR_WIDTH    BRAM word address
//  mem_write_enable_out     out  1                 BRAM write strobe
//  mem_write_data_out       out  Word              BRAM write data
//  mem_read_data_in         in   Word              BRAM read data, MEM_READ_LATENCY after address
// BEHAVIOUR
//  Interface: one clock clk_in; reset rst_n_in is asynchronous, active-low.
//  Reset (async assert, sync release): state IDLE; request_ready_out=1 while IDLE; response_valid_out=0;
//   mem_write_enable_out=0; mem_address_out=0; response_data_out=0; read-return pipeline cleared.
//  Handshake: request accepted on valid&&ready; ready is 1 only in IDLE. Response held stable
//   (data and valid) until response_ready_in; completes on valid&&ready.
//  Base = request_address_in with low CACHE_WORD_OFFSET_WIDTH bits cleared, truncated to MEM_ADDR_WIDTH
//   (upper bits ignored, no error). Word i address = base|i; no carry out of the line.
//  States:
//   IDLE  : accept -> latch base, op, Line; STORE->WRITE, LOAD->READ; counter=0.
//   WRITE : each cycle mem_write_enable_out=1, address base|cnt, data Line[cnt]; cnt++;
//           after word WORDS_PER_LINE-1 -> IDLE. No response generated for STORE.
//   READ  : each cycle issue address base|cnt (write_enable=0), push tag {valid,cnt} into
//           MEM_READ_LATENCY-deep pipeline; after last issue -> DRAIN.
//   DRAIN : when pipeline output valid, capture mem_read_data_in into response_data_out[tag];
//           capture also occurs during READ. When last word captured -> RESPOND.
//   RESPOND: response_valid_out=1 until response_ready_in -> IDLE.
//  Latency: STORE accepted at cycle t -> writes t+1..t+W, ready again t+W+1.
//   LOAD accepted at t -> issues t+1..t+W, last word captured at t+W+L, response_valid at t+W+L+1
//   (W=WORDS_PER_LINE, L=MEM_READ_LATENCY). Back-to-back requests: one idle cycle minimum.
//  Request inputs ignored outside IDLE; new request never overlaps an outstanding one.
//  Reset mid-operation: write strobe drops immediately (asynchronously); partial writes
//   already committed remain; partial fill discarded; no response emitted after reset.
//  response_ready_in asserted while not valid: no effect.
// STRUCTURE
//  Shared packages: Word, MemoryOperation (help); Line, CACHE_WORDS_PER_LINE,
//   CACHE_WORD_OFFSET_WIDTH (cache_help). Add AdapterState enum {IDLE,WRITE,READ,DRAIN,RESPOND} to cache_help.
//  One sub-module: read_tag_pipeline (MEM_READ_LATENCY-stage shift register of {valid, word index}),
//   async active-low reset clearing all valid bits.
// TESTING (W=4, L=2, behavioural BRAM model with latency 2)
//  1 reset then idle: ready=1, response_valid=0, write_enable=0 over 20 cycles.
//  2 STORE addr 0x0000_0013, Line {A0,A1,A2,A3} -> writes to 0x10..0x13 on 4 consecutive cycles, no response, ready after 5 cycles.
//  3 LOAD addr 0x0000_0012 after test 2 -> response_valid 7 cycles after accept, data {A0,A1,A2,A3}.
//  4 LOAD with response_ready_in low 10 cycles -> valid and data stable, request_ready_out=0 throughout.
//  5 LOAD addr 0xFFFF_0020 (MEM_ADDR_WIDTH=16) -> accesses 0x0020..0x0023 (truncation).
//  6 rst_n_in pulsed low mid-WRITE after 2 words -> only 2 words written, strobe drops same cycle, ready=1 after release.

Source files
------------

// File: rtl/l2_line_memory_adapter_pkg.sv
// Shared types for the L2 line-to-word memory adapter: word/line containers,
// memory operation codes and the adapter FSM state encoding.
package l2_line_memory_adapter_pkg;

    localparam int WORD_WIDTH              = 32;
    localparam int CACHE_WORDS_PER_LINE    = 4;
    localparam int CACHE_WORD_OFFSET_WIDTH = $clog2(CACHE_WORDS_PER_LINE);

    typedef logic [WORD_WIDTH-1:0] Word;
    typedef Word [CACHE_WORDS_PER_LINE-1:0] Line;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } MemoryOperation;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WRITE   = 3'd1,
        READ    = 3'd2,
        DRAIN   = 3'd3,
        RESPOND = 3'd4
    } AdapterState;

endpackage

// File: rtl/l2_line_memory_adapter_read_tag_pipeline.sv
// Shift register that carries {valid, word index} alongside each outstanding
// BRAM read so returning data can be steered into the right slot of the line.
module read_tag_pipeline #(
    parameter int DEPTH     = 2,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_valid_i,
    input  logic [IDX_WIDTH-1:0] push_index_i,
    output logic                 pop_valid_o,
    output logic [IDX_WIDTH-1:0] pop_index_o
);

    logic [DEPTH-1:0]                valid_q;
    logic [DEPTH-1:0][IDX_WIDTH-1:0] index_q;

    // Advance every tag one stage per cycle; reset invalidates all in-flight reads.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            index_q <= '0;
        end else begin
            valid_q[0] <= push_valid_i;
            index_q[0] <= push_index_i;
            for (int s = 1; s < DEPTH; s++) begin
                valid_q[s] <= valid_q[s-1];
                index_q[s] <= index_q[s-1];
            end
        end
    end

    assign pop_valid_o = valid_q[DEPTH-1];
    assign pop_index_o = index_q[DEPTH-1];

endmodule

// File: rtl/l2_line_memory_adapter.sv
// Serves line-granular LOAD/STORE requests from a word-wide, fixed-latency BRAM
// port: a line is split into sequential word accesses and reads are reassembled.
module l2_line_memory_adapter
    import l2_line_memory_adapter_pkg::*;
#(
    parameter int MEM_ADDR_WIDTH   = 16,
    parameter int MEM_READ_LATENCY = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    output logic                      request_ready_out,
    input  logic                      request_valid_in,
    input  Word                       request_address_in,
    input  MemoryOperation            request_operation_in,
    input  Line                       request_data_in,
    input  logic                      response_ready_in,
    output logic                      response_valid_out,
    output Line                       response_data_out,
    output logic [MEM_ADDR_WIDTH-1:0] mem_address_out,
    output logic                      mem_write_enable_out,
    output Word                       mem_write_data_out,
    input  Word                       mem_read_data_in
);

    localparam int OFF = CACHE_WORD_OFFSET_WIDTH;
    localparam logic [OFF-1:0] LAST_IDX = OFF'(CACHE_WORDS_PER_LINE - 1);

    AdapterState                     state_q;
    logic [MEM_ADDR_WIDTH-1:OFF]     base_hi_q;
    Line                             line_q;
    logic [OFF-1:0]                  cnt_q;
    logic [OFF-1:0]                  cnt_d;
    logic [MEM_ADDR_WIDTH-1:0]       addr_q;
    logic                            we_q;
    Word                             wdata_q;
    logic                            resp_valid_q;
    Line                             resp_data_q;
    logic                            issue_read_s;
    logic                            tag_valid_s;
    logic [OFF-1:0]                  tag_idx_s;
    logic [MEM_ADDR_WIDTH-1:OFF]     req_base_hi_s;
    logic                            unused_addr_bits_s;

    // Word counter increment and read-issue flag for the tag pipeline.
    always_comb begin
        cnt_d        = cnt_q + OFF'(1'b1);
        issue_read_s = (state_q == READ);
    end

    // Upper address bits beyond the BRAM and the in-line offset are dropped on purpose.
    assign req_base_hi_s      = request_address_in[MEM_ADDR_WIDTH-1:OFF];
    assign unused_addr_bits_s = ^{request_address_in[WORD_WIDTH-1:MEM_ADDR_WIDTH],
                                  request_address_in[OFF-1:0]};

    read_tag_pipeline #(
        .DEPTH     (MEM_READ_LATENCY),
        .IDX_WIDTH (OFF)
    ) u_read_tag_pipeline (
        .clk_i        (clk_in),
        .rst_ni       (rst_n_in),
        .push_valid_i (issue_read_s),
        .push_index_i (cnt_q),
        .pop_valid_o  (tag_valid_s),
        .pop_index_o  (tag_idx_s)
    );

    // Adapter FSM with registered BRAM and response outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            base_hi_q    <= '0;
            line_q       <= '0;
            cnt_q        <= '0;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (request_valid_in) begin
                        base_hi_q <= req_base_hi_s;
                        line_q    <= request_data_in;
                        cnt_q     <= '0;
                        addr_q    <= {req_base_hi_s, {OFF{1'b0}}};
                        if (request_operation_in == STORE) begin
                            state_q <= WRITE;
                            we_q    <= 1'b1;
                            wdata_q <= request_data_in[0];
                        end else begin
                            state_q <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= IDLE;
                        we_q    <= 1'b0;
                    end else begin
                        cnt_q   <= cnt_d;
                        addr_q  <= {base_hi_q, cnt_d};
                        wdata_q <= line_q[cnt_d];
                    end
                end
                READ: begin
                    if (cnt_q == LAST_IDX) begin
                        state_q <= DRAIN;
                    end else begin
                        cnt_q  <= cnt_d;
                        addr_q <= {base_hi_q, cnt_d};
                    end
                end
                DRAIN: begin
                    state_q <= DRAIN;
                end
                RESPOND: begin
                    if (response_ready_in) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    we_q         <= 1'b0;
                    resp_valid_q <= 1'b0;
                end
            endcase

            // Returning words land in their slot; the last one completes the fill.
            if (tag_valid_s && (state_q == READ || state_q == DRAIN)) begin
                resp_data_q[tag_idx_s] <= mem_read_data_in;
                if (tag_idx_s == LAST_IDX) begin
                    state_q      <= RESPOND;
                    resp_valid_q <= 1'b1;
                end
            end
        end
    end

    assign request_ready_out    = (state_q == IDLE);
    assign response_valid_out   = resp_valid_q;
    assign response_data_out    = resp_data_q;
    assign mem_address_out      = addr_q;
    assign mem_write_enable_out = we_q;
    assign mem_write_data_out   = wdata_q;

endmodule

// File: tb/tb_l2_line_memory_adapter.sv
// Directed bench for l2_line_memory_adapter: a cycle-level reference model of the
// line protocol plus a latency-2 BRAM, checked every cycle, with literal spot checks.
module tb_l2_line_memory_adapter;
    import l2_line_memory_adapter_pkg::*;

    localparam int W = CACHE_WORDS_PER_LINE;
    localparam int L = 2;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic           request_ready_out;
    logic           request_valid_in;
    Word            request_address_in;
    MemoryOperation request_operation_in;
    Line            request_data_in;
    logic           response_ready_in;
    logic           response_valid_out;
    Line            response_data_out;
    logic [15:0]    mem_address_out;
    logic           mem_write_enable_out;
    Word            mem_write_data_out;
    Word            mem_read_data_in;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    l2_line_memory_adapter #(
        .MEM_ADDR_WIDTH   (16),
        .MEM_READ_LATENCY (L)
    ) dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .request_ready_out    (request_ready_out),
        .request_valid_in     (request_valid_in),
        .request_address_in   (request_address_in),
        .request_operation_in (request_operation_in),
        .request_data_in      (request_data_in),
        .response_ready_in    (response_ready_in),
        .response_valid_out   (response_valid_out),
        .response_data_out    (response_data_out),
        .mem_address_out      (mem_address_out),
        .mem_write_enable_out (mem_write_enable_out),
        .mem_write_data_out   (mem_write_data_out),
        .mem_read_data_in     (mem_read_data_in)
    );

    // BRAM: synchronous write, read data L cycles after the address.
    Word bram [0:65535];
    Word rd_p0 = '0;
    Word rd_p1 = '0;
    assign mem_read_data_in = rd_p1;
    always @(posedge clk_in) begin
        if (mem_write_enable_out) bram[mem_address_out] <= mem_write_data_out;
        rd_p0 <= bram[mem_address_out];
        rd_p1 <= rd_p0;
    end

    // Reference model: expected memory image plus protocol timing in cycle numbers.
    Word         ref_mem [0:65535];
    int          cyc        = 0;
    bit          st_active  = 1'b0;
    int          st_start   = 0;
    logic [15:0] st_base    = '0;
    Line         st_line    = '0;
    bit          m_pending  = 1'b0;
    int          m_valid_at = 0;
    int          m_ready_at = 0;
    Line         m_line     = '0;

    function automatic Line fill_of(input logic [15:0] b);
        Line l;
        for (int i = 0; i < W; i++) l[i] = ref_mem[b | 16'(i)];
        return l;
    endfunction

    always @(posedge clk_in) begin
        cyc <= cyc + 1;
        if (!rst_n_in) begin
            st_active  <= 1'b0;
            m_pending  <= 1'b0;
            m_ready_at <= 0;
        end else begin
            if (st_active && cyc >= st_start && cyc < st_start + W) begin
                ref_mem[st_base | 16'(cyc - st_start)] <= st_line[cyc - st_start];
                if (cyc == st_start + W - 1) st_active <= 1'b0;
            end
            if (!m_pending && cyc >= m_ready_at && request_valid_in) begin
                if (request_operation_in == STORE) begin
                    st_active  <= 1'b1;
                    st_start   <= cyc + 1;
                    st_base    <= request_address_in[15:0] & 16'hFFFC;
                    st_line    <= request_data_in;
                    m_ready_at <= cyc + 1 + W;
                end else begin
                    m_pending  <= 1'b1;
                    m_valid_at <= cyc + 1 + W + L;
                    m_line     <= fill_of(request_address_in[15:0] & 16'hFFFC);
                end
            end
            if (m_pending && cyc >= m_valid_at && response_ready_in) begin
                m_pending  <= 1'b0;
                m_ready_at <= cyc + 1;
            end
        end
    end

    logic exp_ready;
    logic exp_valid;
    logic exp_we;
    int   exp_widx;
    assign exp_ready = !m_pending && (cyc >= m_ready_at);
    assign exp_valid = m_pending && (cyc >= m_valid_at);
    assign exp_we    = st_active && (cyc >= st_start) && (cyc < st_start + W);
    assign exp_widx  = cyc - st_start;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge clk_in) begin
        check("ready", 128'(request_ready_out), 128'(exp_ready));
        check("resp_valid", 128'(response_valid_out), 128'(exp_valid));
        if (exp_valid) check("resp_data", response_data_out, m_line);
        check("write_en", 128'(mem_write_enable_out), 128'(exp_we));
        if (exp_we) begin
            check("write_addr", 128'(mem_address_out), 128'(st_base | 16'(exp_widx)));
            check("write_data", 128'(mem_write_data_out), 128'(st_line[exp_widx]));
        end
    end

    task automatic send(input MemoryOperation op, input Word addr, input Line data,
                        output int req_cyc);
        int guard;
        guard = 0;
        @(negedge clk_in);
        while (!exp_ready && guard < 100) begin
            @(negedge clk_in);
            guard++;
        end
        check("request_slot", 128'(exp_ready), 128'(1'b1));
        request_valid_in     = 1'b1;
        request_operation_in = op;
        request_address_in   = addr;
        request_data_in      = data;
        req_cyc              = cyc;
        @(negedge clk_in);
        request_valid_in     = 1'b0;
        request_operation_in = STORE;
        request_address_in   = 32'hDEAD_BEEF;
        request_data_in      = {4{32'h5A5A_5A5A}};
    endtask

    task automatic load(input Word addr, input logic pre_ready, input int hold,
                        input Line exp_line, input string tag);
        int  rc;
        int  guard;
        response_ready_in = pre_ready;
        send(LOAD, addr, '0, rc);
        guard = 0;
        while (!response_valid_out && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        check({tag, "_latency"}, 128'(cyc - rc), 128'(W + L + 1));
        check({tag, "_data"}, response_data_out, exp_line);
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_valid"}, 128'(response_valid_out), 128'(1'b1));
            check({tag, "_hold_ready"}, 128'(request_ready_out), 128'(1'b0));
            check({tag, "_hold_data"}, response_data_out, exp_line);
            @(negedge clk_in);
        end
        response_ready_in = 1'b1;
        @(negedge clk_in);
        response_ready_in = 1'b0;
        check({tag, "_valid_drop"}, 128'(response_valid_out), 128'(1'b0));
    endtask

    Line line_a;
    Line line_b;
    Line exp_l;
    int  rc;
    int  guard;

    initial begin
        for (int i = 0; i < 65536; i++) begin
            bram[i]    = 32'hC0DE_0000 | 32'(i);
            ref_mem[i] = 32'hC0DE_0000 | 32'(i);
        end
        rst_n_in             = 1'b0;
        request_valid_in     = 1'b0;
        request_address_in   = '0;
        request_operation_in = LOAD;
        request_data_in      = '0;
        response_ready_in    = 1'b0;
        line_a[0] = 32'hA0A0_0000; line_a[1] = 32'hA1A1_1111;
        line_a[2] = 32'hA2A2_2222; line_a[3] = 32'hA3A3_3333;
        line_b[0] = 32'hB0B0_0000; line_b[1] = 32'hB1B1_1111;
        line_b[2] = 32'hB2B2_2222; line_b[3] = 32'hB3B3_3333;
        repeat (3) @(negedge clk_in);
        #2 rst_n_in = 1'b1;

        // Reset values, then idle with a stray response_ready.
        @(negedge clk_in);
        check("rst_addr", 128'(mem_address_out), 128'(16'h0000));
        check("rst_resp_data", response_data_out, 128'h0);
        for (int i = 0; i < 20; i++) begin
            response_ready_in = (i >= 5 && i < 15);
            check("idle_ready", 128'(request_ready_out), 128'(1'b1));
            check("idle_valid", 128'(response_valid_out), 128'(1'b0));
            check("idle_we", 128'(mem_write_enable_out), 128'(1'b0));
            @(negedge clk_in);
        end
        response_ready_in = 1'b0;

        // STORE to 0x13 covers words 0x10..0x13.
        send(STORE, 32'h0000_0013, line_a, rc);
        guard = 0;
        while (!request_ready_out && guard < 50) begin
            @(negedge clk_in);
            guard++;
        end
        check("store_ready_latency", 128'(cyc - rc), 128'(5));
        check("bram_10", 128'(bram[16'h0010]), 128'(32'hA0A0_0000));
        check("bram_11", 128'(bram[16'h0011]), 128'(32'hA1A1_1111));
        check("bram_12", 128'(bram[16'h0012]), 128'(32'hA2A2_2222));
        check("bram_13", 128'(bram[16'h0013]), 128'(32'hA3A3_3333));
        check("bram_14", 128'(bram[16'h0014]), 128'(32'hC0DE_0014));

        load(32'h0000_0012, 1'b1, 0, line_a, "load_a");
        load(32'h0000_0012, 1'b0, 10, line_a, "load_stall");

        exp_l[0] = 32'hC0DE_0020; exp_l[1] = 32'hC0DE_0021;
        exp_l[2] = 32'hC0DE_0022; exp_l[3] = 32'hC0DE_0023;
        load(32'hFFFF_0020, 1'b1, 0, exp_l, "load_trunc");

        // Reset while the third word of a STORE is on the port.
        send(STORE, 32'h0000_0041, line_b, rc);
        @(negedge clk_in);
        @(negedge clk_in);
        check("pre_rst_we", 128'(mem_write_enable_out), 128'(1'b1));
        check("pre_rst_addr", 128'(mem_address_out), 128'(16'h0042));
        #2 rst_n_in = 1'b0;
        #1 check("rst_we_drop", 128'(mem_write_enable_out), 128'(1'b0));
        @(negedge clk_in);
        @(negedge clk_in);
        #2 rst_n_in = 1'b1;
        @(negedge clk_in);
        check("post_rst_ready", 128'(request_ready_out), 128'(1'b1));
        check("post_rst_valid", 128'(response_valid_out), 128'(1'b0));
        check("bram_40", 128'(bram[16'h0040]), 128'(32'hB0B0_0000));
        check("bram_41", 128'(bram[16'h0041]), 128'(32'hB1B1_1111));
        check("bram_42", 128'(bram[16'h0042]), 128'(32'hC0DE_0042));
        check("bram_43", 128'(bram[16'h0043]), 128'(32'hC0DE_0043));

        exp_l[0] = 32'hB0B0_0000; exp_l[1] = 32'hB1B1_1111;
        exp_l[2] = 32'hC0DE_0042; exp_l[3] = 32'hC0DE_0043;
        load(32'h0000_0040, 1'b1, 0, exp_l, "load_partial");

        repeat (5) @(negedge clk_in);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1);
    end

endmodule
